// File: rtl/mlp_train_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// mlp_train_sequencer_pkg
//   Shared types and helpers for the MLP training sequencer.
//   - sfp_t : signed Q8.8 fixed point used for predictions, targets and loss.
//   - saturating subtract / absolute value / add helpers (no wrap-around).
//   - FSM state encodings for the sequencer.
//   - idx_w(): width of an index able to address n items (minimum 1 bit).
// -----------------------------------------------------------------------------
package mlp_train_sequencer_pkg;

    localparam int SFP_W    = 16;
    localparam int SFP_FRAC = 8;

    typedef logic signed [SFP_W-1:0] sfp_t;

    localparam sfp_t SFP_MAX = {1'b0, {(SFP_W-1){1'b1}}};
    localparam sfp_t SFP_MIN = {1'b1, {(SFP_W-1){1'b0}}};

    // Sequencer states.
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_LOAD      = 3'd1;
    localparam logic [2:0] ST_SETTLE    = 3'd2;
    localparam logic [2:0] ST_UPDATE    = 3'd3;
    localparam logic [2:0] ST_EPOCH_END = 3'd4;
    localparam logic [2:0] ST_DONE      = 3'd5;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // a - b, clamped to [SFP_MIN, SFP_MAX]. Overflow shows up as the two
    // top bits of the one-bit-wider result disagreeing.
    function automatic sfp_t sfp_sub_sat(input sfp_t a, input sfp_t b);
        logic [SFP_W:0] d;
        d = {a[SFP_W-1], a} - {b[SFP_W-1], b};
        if (d[SFP_W] != d[SFP_W-1])
            return d[SFP_W] ? SFP_MIN : SFP_MAX;
        return sfp_t'(d[SFP_W-1:0]);
    endfunction

    // a + b, clamped to [SFP_MIN, SFP_MAX].
    function automatic sfp_t sfp_add_sat(input sfp_t a, input sfp_t b);
        logic [SFP_W:0] s;
        s = {a[SFP_W-1], a} + {b[SFP_W-1], b};
        if (s[SFP_W] != s[SFP_W-1])
            return s[SFP_W] ? SFP_MIN : SFP_MAX;
        return sfp_t'(s[SFP_W-1:0]);
    endfunction

    // |a|; the most negative value has no positive twin, so it maps to SFP_MAX.
    function automatic sfp_t sfp_abs_sat(input sfp_t a);
        if (a == SFP_MIN)
            return SFP_MAX;
        return a[SFP_W-1] ? -a : a;
    endfunction

endpackage

// File: rtl/mlp_train_sequencer_if.sv
// -----------------------------------------------------------------------------
// mlp_train_sequencer_if
//   Bundles the host/datapath side signals of the training sequencer.
//   master : host + layer datapath (drives start/config and prediction/target)
//   slave  : the sequencer (drives sample address, strobes, status, loss)
//   Signals:
//     start, infer_only, max_epochs, loss_thresh, lr_in   run request + config
//     prediction, target                                  datapath results
//     sample_idx, load_en, training, learning_rate        datapath control
//     busy, done, epoch_count, epoch_loss                 status
// -----------------------------------------------------------------------------
interface mlp_train_sequencer_if
    import mlp_train_sequencer_pkg::*;
#(
    parameter int NUM_SAMPLES = 4,
    parameter int EPOCH_W     = 16
);
    localparam int IDX_W = idx_w(NUM_SAMPLES);

    logic               start;
    logic               infer_only;
    logic [EPOCH_W-1:0] max_epochs;
    sfp_t               loss_thresh;
    sfp_t               lr_in;
    sfp_t               prediction;
    sfp_t               target;

    logic [IDX_W-1:0]   sample_idx;
    logic               load_en;
    logic               training;
    sfp_t               learning_rate;
    logic               busy;
    logic               done;
    logic [EPOCH_W-1:0] epoch_count;
    sfp_t               epoch_loss;

    modport master (
        output start, infer_only, max_epochs, loss_thresh, lr_in, prediction, target,
        input  sample_idx, load_en, training, learning_rate, busy, done,
               epoch_count, epoch_loss
    );

    modport slave (
        input  start, infer_only, max_epochs, loss_thresh, lr_in, prediction, target,
        output sample_idx, load_en, training, learning_rate, busy, done,
               epoch_count, epoch_loss
    );

endinterface

// File: rtl/mlp_train_sequencer_loss_accumulator.sv
// -----------------------------------------------------------------------------
// loss_accumulator
//   Saturating accumulator of |prediction - target| for one pass over the
//   sample set.
//   Ports:
//     clk, rst        clock, synchronous active-high reset
//     clear_i         zero the accumulator (wins over en_i)
//     en_i            add the current absolute error
//     prediction_i    output-layer prediction
//     target_i        target for the current sample
//     acc_o           running loss sum (never wraps, clamps at SFP_MAX)
// -----------------------------------------------------------------------------
module loss_accumulator
    import mlp_train_sequencer_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic en_i,
    input  sfp_t prediction_i,
    input  sfp_t target_i,
    output sfp_t acc_o
);
    sfp_t acc_q;
    sfp_t abs_err;

    assign abs_err = sfp_abs_sat(sfp_sub_sat(prediction_i, target_i));

    // NOTE: reset is sampled on the clock edge only; sequential state is
    // assigned with non-blocking (<=) so every flop sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst)
            acc_q <= '0;
        else if (clear_i)
            acc_q <= '0;
        else if (en_i)
            acc_q <= sfp_add_sat(acc_q, abs_err);
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/mlp_train_sequencer.sv
// -----------------------------------------------------------------------------
// mlp_train_sequencer
//   Steps a single-sample MLP datapath through training epochs or one
//   inference pass: LOAD a sample, wait SETTLE_CYCLES for the combinational
//   forward/backward path, then UPDATE (one-cycle training strobe and loss
//   accumulation). After the last sample, EPOCH_END publishes the loss and
//   decides whether to run another epoch or finish.
//   Ports:
//     clk, rst   clock, synchronous active-high reset (aborts a run at once)
//     seq_if     slave side of mlp_train_sequencer_if (config, strobes, status)
//   Parameters:
//     NUM_SAMPLES    samples per epoch (>=1)
//     SETTLE_CYCLES  settle wait after each load (>=1)
//     EPOCH_W        epoch counter width
// -----------------------------------------------------------------------------
module mlp_train_sequencer
    import mlp_train_sequencer_pkg::*;
#(
    parameter int NUM_SAMPLES   = 4,
    parameter int SETTLE_CYCLES = 2,
    parameter int EPOCH_W       = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    mlp_train_sequencer_if.slave  seq_if
);
    localparam int IDX_W = idx_w(NUM_SAMPLES);
    localparam int CNT_W = idx_w(SETTLE_CYCLES);

    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_SAMPLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_TOP = CNT_W'(SETTLE_CYCLES - 1);

    logic [2:0]         state_q,  state_d;
    logic [IDX_W-1:0]   idx_q,    idx_d;
    logic [CNT_W-1:0]   settle_q, settle_d;
    logic [EPOCH_W-1:0] epoch_q,  epoch_d;
    sfp_t               loss_q,   loss_d;

    // Run configuration captured at accept.
    logic               infer_q;
    logic [EPOCH_W-1:0] max_q;
    sfp_t               thresh_q;
    sfp_t               lr_q;

    logic               accept;
    logic               acc_clear;
    logic               acc_en;
    sfp_t               acc;
    logic [EPOCH_W:0]   epoch_inc;

    // One bit wider so the limit test cannot wrap at the top of the counter.
    assign epoch_inc = {1'b0, epoch_q} + (EPOCH_W+1)'(1);

    loss_accumulator u_loss_acc (
        .clk          (clk),
        .rst          (rst),
        .clear_i      (acc_clear),
        .en_i         (acc_en),
        .prediction_i (seq_if.prediction),
        .target_i     (seq_if.target),
        .acc_o        (acc)
    );

    // NOTE: every signal written here gets a default first, so no path
    // through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        settle_d  = settle_q;
        epoch_d   = epoch_q;
        loss_d    = loss_q;
        accept    = 1'b0;
        acc_clear = 1'b0;
        acc_en    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (seq_if.start) begin
                    accept    = 1'b1;
                    idx_d     = '0;
                    epoch_d   = '0;
                    acc_clear = 1'b1;
                    state_d   = ST_LOAD;
                end
            end
            ST_LOAD: begin
                settle_d = SETTLE_TOP;
                state_d  = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (settle_q == '0)
                    state_d = ST_UPDATE;
                else
                    settle_d = settle_q - CNT_W'(1);
            end
            ST_UPDATE: begin
                acc_en = 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = ST_EPOCH_END;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = ST_LOAD;
                end
            end
            ST_EPOCH_END: begin
                loss_d    = acc;
                acc_clear = 1'b1;
                idx_d     = '0;
                if (infer_q) begin
                    state_d = ST_DONE;
                end else begin
                    epoch_d = epoch_inc[EPOCH_W-1:0];
                    if (epoch_inc >= {1'b0, max_q} || acc <= thresh_q)
                        state_d = ST_DONE;
                    else
                        state_d = ST_LOAD;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            settle_q <= '0;
            epoch_q  <= '0;
            loss_q   <= '0;
            infer_q  <= 1'b0;
            max_q    <= '0;
            thresh_q <= '0;
            lr_q     <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            settle_q <= settle_d;
            epoch_q  <= epoch_d;
            loss_q   <= loss_d;
            if (accept) begin
                infer_q  <= seq_if.infer_only;
                // A limit of zero epochs still runs one.
                max_q    <= (seq_if.max_epochs == '0) ? EPOCH_W'(1) : seq_if.max_epochs;
                thresh_q <= seq_if.loss_thresh;
                lr_q     <= seq_if.lr_in;
            end
        end
    end

    // Strobes and status are masked by rst so a reset aborts in the very
    // cycle it is asserted, even if the state register still shows UPDATE.
    assign seq_if.sample_idx    = idx_q;
    assign seq_if.load_en       = (state_q == ST_LOAD) && !rst;
    assign seq_if.training      = (state_q == ST_UPDATE) && !infer_q && !rst;
    assign seq_if.busy          = (state_q != ST_IDLE) && !rst;
    assign seq_if.done          = (state_q == ST_DONE) && !rst;
    assign seq_if.learning_rate = lr_q;
    assign seq_if.epoch_count   = epoch_q;
    assign seq_if.epoch_loss    = loss_q;

endmodule
